charbuf_seq_ctrl: RTL and testbench
===================================

# charbuf_seq_ctrl

Sequencing engine for the text-mode character buffer's CPU-side port. It performs bulk clear (fill all 80x30 cells with one byte) and scroll-up-one-line (copy rows 1..29 to rows 0..28, fill row 29) without CPU involvement. It also arbitrates the port between the engine and ordinary CPU register writes. It sits between the video register decode and port A of the character buffer dual-port RAM. The display-side port B is untouched.

## Interface
Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows per screen
- ADDR_W, 12, character buffer address width
- DATA_W, 8, cell width

Ports:
- clk_i  in  1  system/pixel clock; one clock domain
- rst_n_i  in  1  reset, asynchronous assert, active-low
- cmd_valid_i  in  1  command strobe, sampled on rising edge
- cmd_i  in  2  2'b01 clear, 2'b10 scroll; 2'b00/2'b11 ignored
- fill_i  in  DATA_W  fill byte, captured with the command
- busy_o  out  1  engine owns port A
- done_o  out  1  one-cycle completion pulse
- cpu_we_i  in  1  CPU write request to the buffer (already decoded)
- cpu_addr_i  in  ADDR_W  CPU cell address (line*80+col)
- cpu_data_i  in  DATA_W  CPU write data
- cpu_drop_o  out  1  one-cycle pulse: CPU write discarded because busy
- ram_we_o  out  1  port A write enable
- ram_addr_o  out  ADDR_W  port A address
- ram_din_o  out  DATA_W  port A write data
- ram_dout_i  in  DATA_W  port A read data, valid the cycle after the address is presented

## Operation
- States: IDLE, CLR, CP_RD, CP_WR, FILL, DONE. Registers: state, cnt (ADDR_W), fill byte, read-data holding path.
- IDLE: ram_we_o/addr/din pass cpu_we_i/cpu_addr_i/cpu_data_i through combinationally. busy_o=0.
- Accept: cmd_valid_i in IDLE with a legal cmd_i. Captures fill_i and clears cnt to 0. Goes to CLR (01) or CP_RD (10). Illegal codes leave state unchanged.
- CLR: writes fill to address cnt and increments cnt. After cnt=COLS*ROWS-1 (2399), goes to DONE.
- CP_RD: ram_addr_o=cnt+COLS, we=0. Next state is CP_WR.
- CP_WR: ram_addr_o=cnt, ram_din_o=ram_dout_i, we=1, cnt++. Goes to FILL after cnt=COLS*(ROWS-1)-1 (2319), else back to CP_RD.
- FILL: writes fill to cnt for cnt=2320..2399, then goes to DONE.
- DONE: done_o=1, busy_o=1, port idle (we=0). Goes to IDLE next.
- While busy_o=1: cmd_valid_i is ignored (no queue). cpu_we_i is not forwarded and pulses cpu_drop_o the same cycle. CPU reads return don't-care data.
- Address arithmetic: unsigned ADDR_W bits. cnt+COLS never exceeds 2399 in CP_RD.
- Reset mid-operation: state goes to IDLE immediately, all outputs take reset values, and the partially updated buffer is left as is.

## Timing
- Reset values: busy_o=0, done_o=0, cpu_drop_o=0, ram_we_o=0 (pass-through of CPU inputs once out of reset), state=IDLE, cnt=0.
- busy_o rises the cycle after the accepting edge. It falls the cycle after DONE.
- Clear: 2400 write cycles + 1 DONE cycle; busy_o high for 2401 cycles.
- Scroll: 2320×2 copy cycles + 80 fill cycles + 1 DONE cycle = 4721 cycles busy.
- A new command is accepted in the first IDLE cycle after DONE. There is no back-to-back acceptance during DONE.
- A cmd_valid_i and cpu_we_i in the same IDLE cycle: the CPU write is performed that cycle and the command is accepted. The engine's first access is the following cycle.
- All engine-driven port outputs are decoded combinationally from registered state/cnt/fill only. No combinational path runs from cmd_* to ram_*.

## Structure
- Shared package video_pkg holds:
  - COLS, ROWS, CELLS (2400), SCROLL_CELLS (2320)
  - command encodings CMD_CLEAR/CMD_SCROLL
  - state enum charbuf_seq_state_t
- Single module; no sub-module is natural, since the counter and mux are inline.

## Test plan
- Clear with fill_i=8'h20: all 2400 cells read back 8'h20. done_o pulses exactly once, 2401 cycles after accept. busy_o is high the whole time.
- Scroll on a buffer preloaded with cell=row: rows 0..28 read back 1..29 and row 29 reads fill_i=8'h2E. Busy lasts 4721 cycles.
- CPU write to addr 5 while busy: cpu_drop_o pulses, the cell is unchanged after the op, and engine output is unaffected.
- cmd_valid_i with cmd_i=2'b10 during an active clear: ignored, exactly one done_o. Illegal cmd_i=2'b11 in IDLE: busy_o stays 0.
- Simultaneous cpu_we_i (addr 100, 8'hAA) and clear command in IDLE: the CPU write lands first, then cell 100 ends as the fill byte.
- rst_n_i asserted at cycle 1000 of a scroll: busy_o/done_o/ram_we_o drop to 0 asynchronously, and the next clear completes normally.

Source files
------------

// File: rtl/video_pkg.sv
// ============================================================================
// Module   : video_pkg
// Purpose  : Shared text-mode geometry, sequencer command codes and states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_pkg;

    localparam int COLS         = 80;
    localparam int ROWS         = 30;
    localparam int CELLS        = COLS * ROWS;
    localparam int SCROLL_CELLS = COLS * (ROWS - 1);

    localparam logic [1:0] CMD_CLEAR  = 2'b01;
    localparam logic [1:0] CMD_SCROLL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_CP_RD = 3'd2,
        ST_CP_WR = 3'd3,
        ST_FILL  = 3'd4,
        ST_DONE  = 3'd5
    } charbuf_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/charbuf_seq_ctrl_if.sv
// ============================================================================
// Module   : charbuf_seq_ctrl_if
// Purpose  : Command, CPU-write and RAM port-A bundle of the char-buffer sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface charbuf_seq_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              cmd_valid_i;
    logic [1:0]        cmd_i;
    logic [DATA_W-1:0] fill_i;
    logic              busy_o;
    logic              done_o;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_data_i;
    logic              cpu_drop_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_din_o;
    logic [DATA_W-1:0] ram_dout_i;

    // Host side: register decode plus the RAM returning read data.
    modport master (
        output cmd_valid_i, cmd_i, fill_i, cpu_we_i, cpu_addr_i, cpu_data_i, ram_dout_i,
        input  busy_o, done_o, cpu_drop_o, ram_we_o, ram_addr_o, ram_din_o
    );

    modport slave (
        input  cmd_valid_i, cmd_i, fill_i, cpu_we_i, cpu_addr_i, cpu_data_i, ram_dout_i,
        output busy_o, done_o, cpu_drop_o, ram_we_o, ram_addr_o, ram_din_o
    );
endinterface

`default_nettype wire

// File: rtl/charbuf_seq_ctrl.sv
// ============================================================================
// Module   : charbuf_seq_ctrl
// Purpose  : Bulk clear / scroll-up engine and CPU arbiter for char-buffer port A.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module charbuf_seq_ctrl #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  wire logic         clk_i,
    input  wire logic         rst_n_i,
    charbuf_seq_ctrl_if.slave bus
);
    import video_pkg::*;

    localparam logic [ADDR_W-1:0] c_COLS      = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] c_LAST_CELL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] c_LAST_COPY = ADDR_W'(COLS * (ROWS - 1) - 1);

    charbuf_seq_state_t r_state;
    logic [ADDR_W-1:0]  r_cnt;
    logic [DATA_W-1:0]  r_fill;
    logic               r_busy;
    logic               r_done;

    logic               w_legal;
    logic               w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_din;

    assign w_legal = (bus.cmd_i == CMD_CLEAR) || (bus.cmd_i == CMD_SCROLL);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_fill  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid_i && w_legal) begin
                        r_fill  <= bus.fill_i;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (bus.cmd_i == CMD_CLEAR) ? ST_CLR : ST_CP_RD;
                    end
                end
                ST_CLR, ST_FILL: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_CELL) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_CP_RD: r_state <= ST_CP_WR;
                ST_CP_WR: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= (r_cnt == c_LAST_COPY) ? ST_FILL : ST_CP_RD;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Engine accesses depend only on registered state; the source row of a
    // copy is read one row ahead and its data arrives during CP_WR.
    always_comb begin
        w_we   = 1'b0;
        w_addr = r_cnt;
        w_din  = r_fill;
        case (r_state)
            ST_IDLE: begin
                w_we   = bus.cpu_we_i;
                w_addr = bus.cpu_addr_i;
                w_din  = bus.cpu_data_i;
            end
            ST_CLR, ST_FILL: w_we = 1'b1;
            ST_CP_RD: w_addr = r_cnt + c_COLS;
            ST_CP_WR: begin
                w_we  = 1'b1;
                w_din = bus.ram_dout_i;
            end
            default: w_we = 1'b0;
        endcase
    end

    assign bus.busy_o     = r_busy;
    assign bus.done_o     = r_done;
    assign bus.cpu_drop_o = r_busy & bus.cpu_we_i;
    assign bus.ram_we_o   = w_we;
    assign bus.ram_addr_o = w_addr;
    assign bus.ram_din_o  = w_din;

endmodule

`default_nettype wire

// File: tb/tb_charbuf_seq_ctrl.sv
// ============================================================================
// Module   : tb_charbuf_seq_ctrl
// Purpose  : Scoreboard bench for charbuf_seq_ctrl against a cell-array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_charbuf_seq_ctrl;
    import video_pkg::*;

    localparam int AW          = 12;
    localparam int DW          = 8;
    localparam int BUSY_CLEAR  = CELLS + 1;
    localparam int BUSY_SCROLL = 2 * SCROLL_CELLS + (CELLS - SCROLL_CELLS) + 1;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    charbuf_seq_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    charbuf_seq_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    // Port-A RAM: registered read, one cycle latency.
    logic [DW-1:0] ram [0:4095];
    logic [DW-1:0] r_dout;
    always @(posedge clk_i) begin
        if (bus.ram_we_o) ram[bus.ram_addr_o] <= bus.ram_din_o;
        r_dout <= ram[bus.ram_addr_o];
    end
    assign bus.ram_dout_i = r_dout;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_wr[$];
    int            exp_len[$];
    logic [DW-1:0] model [0:CELLS-1];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            done_cnt = 0;
    int            done_target = 0;
    int            run = 0;
    bit            op_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor: every port-A write and every done pulse is matched against the queues.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                run = 0;
            end else begin
                if (bus.ram_we_o) begin
                    if (exp_wr.size() == 0) begin
                        fail("unexpected_write");
                    end else begin
                        w = exp_wr.pop_front();
                        check("wr_addr", 32'(bus.ram_addr_o), 32'(w.addr));
                        check("wr_data", 32'(bus.ram_din_o), 32'(w.data));
                    end
                end
                run = bus.busy_o ? run + 1 : 0;
                if (bus.done_o) begin
                    done_cnt++;
                    if (exp_len.size() == 0) fail("unexpected_done");
                    else check("busy_len_at_done", run, exp_len.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit drop;
        drop = op_active;
        bus.cpu_we_i   = 1'b1;
        bus.cpu_addr_i = a;
        bus.cpu_data_i = d;
        if (!drop) begin
            exp_wr.push_back(wr_t'{addr: a, data: d});
            model[a] = d;
        end
        @(negedge clk_i);
        check("cpu_drop", 32'(bus.cpu_drop_o), 32'(drop));
        step();
        bus.cpu_we_i = 1'b0;
    endtask

    task automatic issue(input logic [1:0] c, input logic [DW-1:0] f,
                         input bit with_cpu, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] v;
        if (with_cpu && !op_active) begin
            bus.cpu_we_i   = 1'b1;
            bus.cpu_addr_i = a;
            bus.cpu_data_i = d;
            exp_wr.push_back(wr_t'{addr: a, data: d});
            model[a] = d;
        end
        bus.cmd_valid_i = 1'b1;
        bus.cmd_i       = c;
        bus.fill_i      = f;
        if (!op_active && (c == CMD_CLEAR || c == CMD_SCROLL)) begin
            for (int i = 0; i < CELLS; i++) begin
                if (c == CMD_SCROLL && i < SCROLL_CELLS) v = model[i + COLS];
                else v = f;
                exp_wr.push_back(wr_t'{addr: AW'(i), data: v});
                model[i] = v;
            end
            exp_len.push_back(c == CMD_CLEAR ? BUSY_CLEAR : BUSY_SCROLL);
            op_active   = 1'b1;
            done_target = done_cnt + 1;
        end
        step();
        bus.cmd_valid_i = 1'b0;
        bus.cpu_we_i    = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_cnt < done_target && k < 6000) begin
            step();
            k++;
        end
        if (done_cnt < done_target) fail("done_timeout");
        op_active = 1'b0;
    endtask

    task automatic mem_check(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (ram[i] !== model[i]) bad++;
        check(name, bad, 0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic [DW-1:0] rf;
        logic [1:0]    rc;
        for (int i = 0; i < 4096; i++) ram[i] = '0;
        for (int i = 0; i < CELLS; i++) model[i] = '0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_i       = 2'b00;
        bus.fill_i      = '0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_addr_i  = '0;
        bus.cpu_data_i  = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_busy", 32'(bus.busy_o), 0);
        check("rst_done", 32'(bus.done_o), 0);
        check("rst_drop", 32'(bus.cpu_drop_o), 0);
        check("rst_we", 32'(bus.ram_we_o), 0);
        rst_n_i = 1'b1;
        step();

        // Preload every cell with its row number.
        for (int i = 0; i < CELLS; i++) cpu_write(AW'(i), DW'(i / COLS));
        mem_check("preload");

        // Scroll, with a dropped CPU write and an ignored command while busy.
        issue(CMD_SCROLL, 8'h2E, 1'b0, '0, '0);
        repeat (20) step();
        cpu_write(12'd5, 8'hFF);
        issue(CMD_CLEAR, 8'h55, 1'b0, '0, '0);
        wait_done();
        mem_check("scroll_mem");
        check("scroll_row0", 32'(ram[0]), 1);
        check("scroll_cell5", 32'(ram[5]), 1);
        check("scroll_row28", 32'(ram[28 * COLS + 7]), 29);
        check("scroll_row29", 32'(ram[29 * COLS + 79]), 32'h2E);

        // CPU write and clear command in the same idle cycle.
        issue(CMD_CLEAR, 8'h20, 1'b1, 12'd100, 8'hAA);
        repeat (5) step();
        issue(CMD_SCROLL, 8'h11, 1'b0, '0, '0);
        wait_done();
        mem_check("clear_mem");
        check("clear_cell100", 32'(ram[100]), 32'h20);

        // Illegal command codes leave the engine idle.
        issue(2'b11, 8'h77, 1'b0, '0, '0);
        issue(2'b00, 8'h77, 1'b0, '0, '0);
        repeat (3) begin
            @(negedge clk_i);
            check("illegal_busy", 32'(bus.busy_o), 0);
        end
        step();

        for (int k = 0; k < 3; k++) begin
            repeat (4) begin
                ra = AW'($urandom_range(0, CELLS - 1));
                rd = DW'($urandom);
                cpu_write(ra, rd);
            end
            rc = 2'($urandom_range(1, 2));
            rf = DW'($urandom);
            ra = AW'($urandom_range(0, CELLS - 1));
            rd = DW'($urandom);
            issue(rc, rf, 1'($urandom_range(0, 1)), ra, rd);
            repeat ($urandom_range(1, 30)) step();
            ra = AW'($urandom_range(0, CELLS - 1));
            rd = DW'($urandom);
            cpu_write(ra, rd);
            rc = 2'($urandom_range(0, 3));
            issue(rc, rd, 1'b0, '0, '0);
            wait_done();
            mem_check("random_op_mem");
        end

        // Asynchronous reset in the middle of a scroll, then a normal clear.
        issue(CMD_SCROLL, 8'h3C, 1'b0, '0, '0);
        repeat (999) step();
        #2;
        rst_n_i = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy_o), 0);
        check("midrst_done", 32'(bus.done_o), 0);
        check("midrst_we", 32'(bus.ram_we_o), 0);
        exp_wr.delete();
        exp_len.delete();
        op_active = 1'b0;
        repeat (2) step();
        rst_n_i = 1'b1;
        step();
        issue(CMD_CLEAR, 8'h07, 1'b0, '0, '0);
        wait_done();
        mem_check("clear_after_reset");

        repeat (2) step();
        check("pending_writes", exp_wr.size(), 0);
        check("pending_ops", exp_len.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
